// File: rtl/width_reduce_serializer.sv
// Splits an IN_WIDTH word into NSLICE OUT_WIDTH slices, LSB first, over valid/ready.
// Define SIGNED_FIT_EN to make 'fits' test sign-extension instead of zero-extension.
module width_reduce_serializer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2,
  localparam int NSLICE   = IN_WIDTH / OUT_WIDTH,
  localparam int IDXW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last,
  output logic                 fits
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDXW-1:0]     IDX_ZERO  = IDXW'(0);
  localparam logic [IDXW-1:0]     IDX_ONE   = IDXW'(1);
  localparam logic [IDXW-1:0]     IDX_LAST  = IDXW'(NSLICE - 1);
  localparam logic [IN_WIDTH-1:0] WORD_ZERO = {IN_WIDTH{1'b0}};

  // True when the whole word is recoverable from its low slice.
  function automatic logic fit_check(input logic [IN_WIDTH-1:0] w);
`ifdef SIGNED_FIT_EN
    logic [IN_WIDTH-OUT_WIDTH:0] hi;
    hi = w[IN_WIDTH-1:OUT_WIDTH-1];
    return (hi == {(IN_WIDTH-OUT_WIDTH+1){1'b0}}) || (hi == {(IN_WIDTH-OUT_WIDTH+1){1'b1}});
`else
    logic [IN_WIDTH-OUT_WIDTH-1:0] hi;
    hi = w[IN_WIDTH-1:OUT_WIDTH];
    return hi == {(IN_WIDTH-OUT_WIDTH){1'b0}};
`endif
  endfunction

  state_t              state_r, state_s;
  logic [IN_WIDTH-1:0] shreg_r, shreg_s;
  logic [IDXW-1:0]     idx_r, idx_s;
  logic                fits_r, fits_s;
  logic                last_s, accept_s, take_s;

  // Handshake decode; in_ready depends combinationally on out_ready for gapless reload.
  always_comb begin
    last_s    = (state_r == SEND) && (idx_r == IDX_LAST);
    in_ready  = reset && ((state_r == IDLE) || (last_s && out_ready));
    out_valid = reset && (state_r == SEND);
    accept_s  = in_valid && in_ready;
    take_s    = out_valid && out_ready;
  end

  // Next-state logic; registers are cleared on return to IDLE so idle outputs read 0.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    idx_s   = idx_r;
    fits_s  = fits_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SEND;
          shreg_s = in_data;
          idx_s   = IDX_ZERO;
          fits_s  = fit_check(in_data);
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (take_s && last_s && accept_s) begin
          state_s = SEND;
          shreg_s = in_data;
          idx_s   = IDX_ZERO;
          fits_s  = fit_check(in_data);
        end else if (take_s && last_s) begin
          state_s = IDLE;
          shreg_s = WORD_ZERO;
          idx_s   = IDX_ZERO;
          fits_s  = 1'b0;
        end else if (take_s) begin
          shreg_s = shreg_r >> OUT_WIDTH;
          idx_s   = idx_r + IDX_ONE;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        shreg_s = WORD_ZERO;
        idx_s   = IDX_ZERO;
        fits_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      shreg_r <= WORD_ZERO;
      idx_r   <= IDX_ZERO;
      fits_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      idx_r   <= idx_s;
      fits_r  <= fits_s;
    end
  end

  assign out_data = shreg_r[OUT_WIDTH-1:0];
  assign out_idx  = idx_r;
  assign out_last = last_s;
  assign fits     = fits_r;

endmodule

// File: tb/tb_width_reduce_serializer.sv
// Directed self-checking bench for width_reduce_serializer (8 -> 2 bits).
module tb_width_reduce_serializer;

`ifdef SIGNED_FIT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
  logic       fits;

  int total = 0;
  int bad = 0;

  width_reduce_serializer #(.IN_WIDTH(8), .OUT_WIDTH(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .fits(fits)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Checks one live slice at mid-cycle.
  task automatic chk_slice(input string tag, input logic [1:0] d, input logic [1:0] i,
                           input logic f);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".idx"}, out_idx, i);
    chk({tag, ".last"}, out_last, (i == 2'd3));
    chk({tag, ".fits"}, fits, f);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".idle_valid"}, out_valid, 1'b0);
    chk({tag, ".idle_ready"}, in_ready, 1'b1);
    chk({tag, ".idle_idx"}, out_idx, 2'd0);
    chk({tag, ".idle_last"}, out_last, 1'b0);
  endtask

  // Full word with out_ready=1; s holds hand-written slices {s3,s2,s1,s0}.
  task automatic send_word(input string tag, input logic [7:0] d, input logic [7:0] s,
                           input logic f);
    logic [1:0] sl;
    in_valid = 1'b1;
    in_data = d;
    out_ready = 1'b1;
    #3;
    chk({tag, ".accept"}, in_ready, 1'b1);
    step;
    in_valid = 1'b0;
    in_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      #3;
      sl = s[2*i +: 2];
      chk_slice(tag, sl, 2'(i), f);
      step;
    end
    #3;
    chk_idle(tag);
    step;
  endtask

  initial begin
    // Reset held low for three cycles
    repeat (3) begin
      step;
      #3;
      chk("rst.in_ready", in_ready, 1'b0);
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.out_data", out_data, 2'b00);
      chk("rst.out_idx", out_idx, 2'd0);
      chk("rst.out_last", out_last, 1'b0);
      chk("rst.fits", fits, 1'b0);
    end
    step;
    reset = 1'b1;
    #3;
    chk("rel.in_ready", in_ready, 1'b1);
    chk("rel.out_valid", out_valid, 1'b0);
    step;

    send_word("b4", 8'hB4, {2'b10, 2'b11, 2'b01, 2'b00}, 1'b0);
    send_word("03", 8'h03, {2'b00, 2'b00, 2'b00, 2'b11}, !SGN);
    send_word("fe", 8'hFE, {2'b11, 2'b11, 2'b11, 2'b10}, SGN);
    send_word("01", 8'h01, {2'b00, 2'b00, 2'b00, 2'b01}, 1'b1);

    // Stall at idx 1
    in_valid = 1'b1;
    in_data = 8'hB4;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    #3;
    chk_slice("stall0", 2'b00, 2'd0, 1'b0);
    step;
    out_ready = 1'b0;
    repeat (3) begin
      #3;
      chk_slice("stall_hold", 2'b01, 2'd1, 1'b0);
      chk("stall.in_ready", in_ready, 1'b0);
      step;
    end
    out_ready = 1'b1;
    #3;
    chk_slice("stall1", 2'b01, 2'd1, 1'b0);
    step;
    #3;
    chk_slice("stall2", 2'b11, 2'd2, 1'b0);
    step;
    #3;
    chk_slice("stall3", 2'b10, 2'd3, 1'b0);
    step;
    #3;
    chk_idle("stall");
    step;

    // Back-to-back 0x1B then 0xE4
    in_valid = 1'b1;
    in_data = 8'h1B;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    #3;
    chk_slice("b2b_a0", 2'b11, 2'd0, 1'b0);
    step;
    #3;
    chk_slice("b2b_a1", 2'b10, 2'd1, 1'b0);
    step;
    #3;
    chk_slice("b2b_a2", 2'b01, 2'd2, 1'b0);
    step;
    in_valid = 1'b1;
    in_data = 8'hE4;
    #3;
    chk_slice("b2b_a3", 2'b00, 2'd3, 1'b0);
    chk("b2b.in_ready", in_ready, 1'b1);
    step;
    in_valid = 1'b0;
    #3;
    chk_slice("b2b_b0", 2'b00, 2'd0, 1'b0);
    step;
    #3;
    chk_slice("b2b_b1", 2'b01, 2'd1, 1'b0);
    step;
    #3;
    chk_slice("b2b_b2", 2'b10, 2'd2, 1'b0);
    step;
    #3;
    chk_slice("b2b_b3", 2'b11, 2'd3, 1'b0);
    step;
    #3;
    chk_idle("b2b");
    step;

    // Reset pulse at idx 2
    in_valid = 1'b1;
    in_data = 8'hB4;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
    #3;
    chk_slice("mid2", 2'b11, 2'd2, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid.rst_valid", out_valid, 1'b0);
    chk("mid.rst_ready", in_ready, 1'b0);
    step;
    reset = 1'b1;
    repeat (2) begin
      #3;
      chk_idle("mid");
      chk("mid.data", out_data, 2'b00);
      chk("mid.fits", fits, 1'b0);
      step;
    end
    send_word("post03", 8'h03, {2'b00, 2'b00, 2'b00, 2'b11}, !SGN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
